// File: rtl/fe_pkg.sv
// Shared front-end types and constants for the next-PC stage and its checkpoint FIFO.
package fe_pkg;

  localparam int PC_W = 16;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    CC = 2'b00,
    B  = 2'b01,
    BL = 2'b10,
    BX = 2'b11
  } branch_op_e;

  localparam int  PC_INC   = 2;
  localparam pc_t RESET_PC = 16'h0000;

endpackage

// File: rtl/fe_spec_fifo.sv
// In-order checkpoint FIFO holding the alternate PC of each in-flight speculative branch.
module fe_spec_fifo #(
  parameter int PC_WIDTH   = 16,
  parameter int SPEC_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          push_i,
  input  logic [PC_WIDTH-1:0]           push_pc_i,
  input  logic                          pop_i,
  input  logic                          clear_i,
  output logic [PC_WIDTH-1:0]           head_pc_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(SPEC_DEPTH):0]   count_o
);

  import fe_pkg::*;

  localparam int AW = $clog2(SPEC_DEPTH);

  logic [PC_WIDTH-1:0] mem [SPEC_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;

  // Extra wrap bit on each pointer distinguishes full from empty.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_i)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem[wr_ptr[AW-1:0]] <= push_pc_i;
  end

  assign head_pc_o = mem[rd_ptr[AW-1:0]];
  assign count_o   = wr_ptr - rd_ptr;
  assign empty_o   = (wr_ptr == rd_ptr);
  assign full_o    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fe_pc_gen.sv
// Front-end next-PC generator with speculative-branch checkpointing and redirect handling.
// Optional branch statistics counters are enabled by defining FE_PC_GEN_STATS_EN.
module fe_pc_gen #(
  parameter int                  PC_WIDTH   = fe_pkg::PC_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = fe_pkg::RESET_PC,
  parameter int                  PC_INC     = fe_pkg::PC_INC,
  parameter int                  SPEC_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          inst_v_i,
  input  logic                          take_branch_i,
  input  logic                          speculative_i,
  input  logic [PC_WIDTH-1:0]           branch_offset_i,
  input  logic                          fetch_ready_i,
  input  logic                          resolve_v_i,
  input  logic                          resolve_mispredict_i,
  input  logic                          redirect_v_i,
  input  logic [PC_WIDTH-1:0]           redirect_pc_i,
`ifdef FE_PC_GEN_STATS_EN
  output logic [15:0]                   spec_branches_o,
  output logic [15:0]                   mispredicts_o,
`endif
  output logic [PC_WIDTH-1:0]           pc_o,
  output logic                          pc_v_o,
  output logic                          stall_o,
  output logic                          flush_o,
  output logic [$clog2(SPEC_DEPTH):0]   spec_count_o
);

  import fe_pkg::*;

  localparam int                  CW  = $clog2(SPEC_DEPTH) + 1;
  localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(PC_INC);

  logic [PC_WIDTH-1:0] pc_p0;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] tgt_pc;
  logic [PC_WIDTH-1:0] alt_pc;
  logic [PC_WIDTH-1:0] head_pc;
  logic                vld_p0;
  logic                flush_p0;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                mispredict;
  logic                resolve_ok;
  logic                stall;
  logic                advance;
  logic                clear;
  logic                push;
  logic                pop;

  always_comb begin
    seq_pc     = pc_p0 + INC;
    tgt_pc     = pc_p0 + branch_offset_i;
    alt_pc     = take_branch_i ? seq_pc : tgt_pc;
    mispredict = !redirect_v_i && resolve_v_i && resolve_mispredict_i && !fifo_empty;
    resolve_ok = resolve_v_i && !resolve_mispredict_i && !fifo_empty;
    // A full FIFO only blocks a new speculative branch if nothing retires this cycle.
    stall      = vld_p0 && !redirect_v_i && !mispredict && inst_v_i && speculative_i &&
                 fifo_full && !(resolve_v_i && !resolve_mispredict_i);
    advance    = vld_p0 && !stall && fetch_ready_i;
    clear      = redirect_v_i || mispredict;
    pop        = resolve_ok && !clear;
    push       = !clear && advance && inst_v_i && speculative_i;

    pc_nxt = pc_p0;
    if (redirect_v_i)   pc_nxt = redirect_pc_i;
    else if (mispredict) pc_nxt = head_pc;
    else if (advance)    pc_nxt = (inst_v_i && take_branch_i) ? tgt_pc : seq_pc;
  end

  // Stage p0: architectural fetch PC, valid and flush pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_p0    <= RESET_PC;
      vld_p0   <= 1'b0;
      flush_p0 <= 1'b0;
    end else begin
      pc_p0    <= pc_nxt;
      vld_p0   <= 1'b1;
      flush_p0 <= clear;
    end
  end

  fe_spec_fifo #(
    .PC_WIDTH   (PC_WIDTH),
    .SPEC_DEPTH (SPEC_DEPTH)
  ) u_spec_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_i    (push),
    .push_pc_i (alt_pc),
    .pop_i     (pop),
    .clear_i   (clear),
    .head_pc_o (head_pc),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign pc_o         = pc_p0;
  assign pc_v_o       = vld_p0 && !stall;
  assign stall_o      = stall;
  assign flush_o      = flush_p0;
  assign spec_count_o = fifo_count;

`ifdef FE_PC_GEN_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] spec_cnt_p0;
  logic [15:0] mis_cnt_p0;

  // Stage p0: saturating event counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      spec_cnt_p0 <= '0;
      mis_cnt_p0  <= '0;
    end else begin
      if (push)       spec_cnt_p0 <= sat_inc(spec_cnt_p0);
      if (mispredict) mis_cnt_p0  <= sat_inc(mis_cnt_p0);
    end
  end

  assign spec_branches_o = spec_cnt_p0;
  assign mispredicts_o   = mis_cnt_p0;
`endif

  // Resolving with no outstanding speculative branch is a backend protocol error.
  assert property (@(posedge clk_i) disable iff (reset_i) !(resolve_v_i && fifo_empty));

endmodule

// File: tb/tb_fe_pc_gen.sv
// Bench for fe_pc_gen: queue-based reference model checked every cycle plus literal spot checks.
module tb_fe_pc_gen;

  localparam int D = 4;

  logic        clk      = 1'b0;
  logic        reset_i  = 1'b1;
  logic        inst_v   = 1'b0;
  logic        take     = 1'b0;
  logic        spec     = 1'b0;
  logic [15:0] off      = 16'h0000;
  logic        ready    = 1'b1;
  logic        res_v    = 1'b0;
  logic        res_m    = 1'b0;
  logic        redir_v  = 1'b0;
  logic [15:0] redir_pc = 16'h0000;

  logic [15:0] pc;
  logic        pc_v;
  logic        stall;
  logic        flush;
  logic [2:0]  cnt;
`ifdef FE_PC_GEN_STATS_EN
  logic [15:0] sb;
  logic [15:0] mp;
`endif

  always #5 clk = ~clk;

  fe_pc_gen #(
    .PC_WIDTH   (16),
    .RESET_PC   (16'h0000),
    .PC_INC     (2),
    .SPEC_DEPTH (D)
  ) dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .inst_v_i             (inst_v),
    .take_branch_i        (take),
    .speculative_i        (spec),
    .branch_offset_i      (off),
    .fetch_ready_i        (ready),
    .resolve_v_i          (res_v),
    .resolve_mispredict_i (res_m),
    .redirect_v_i         (redir_v),
    .redirect_pc_i        (redir_pc),
`ifdef FE_PC_GEN_STATS_EN
    .spec_branches_o      (sb),
    .mispredicts_o        (mp),
`endif
    .pc_o                 (pc),
    .pc_v_o               (pc_v),
    .stall_o              (stall),
    .flush_o              (flush),
    .spec_count_o         (cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: fetch PC, started flag, pending flush and a queue of alternate PCs.
  logic [15:0] m_pc    = 16'h0000;
  bit          m_run   = 1'b0;
  bit          m_flush = 1'b0;
  logic [15:0] m_q[$];
  int unsigned m_sb    = 0;
  int unsigned m_mp    = 0;
  bit          m_stall;
  bit          m_misp;
  logic [15:0] m_seq;
  logic [15:0] m_tgt;

  always begin
    @(negedge clk);
    #3;
    if (reset_i) begin
      m_pc    = 16'h0000;
      m_run   = 1'b0;
      m_flush = 1'b0;
      m_q.delete();
      m_sb    = 0;
      m_mp    = 0;
    end
    m_misp  = !redir_v && res_v && res_m && (m_q.size() > 0);
    m_stall = m_run && !redir_v && !m_misp && inst_v && spec &&
              (m_q.size() == D) && !(res_v && !res_m);
    chk("pc",    pc,    m_pc);
    chk("pc_v",  pc_v,  m_run && !m_stall);
    chk("stall", stall, m_stall);
    chk("flush", flush, m_flush);
    chk("count", cnt,   m_q.size());
`ifdef FE_PC_GEN_STATS_EN
    chk("spec_branches", sb, m_sb);
    chk("mispredicts",   mp, m_mp);
`endif
    if (!reset_i) begin
      m_seq = m_pc + 16'd2;
      m_tgt = m_pc + off;
      if (redir_v) begin
        m_pc = redir_pc;
        m_q.delete();
        m_flush = 1'b1;
      end else if (m_misp) begin
        m_pc = m_q[0];
        m_q.delete();
        m_flush = 1'b1;
        if (m_mp < 65535) m_mp++;
      end else begin
        m_flush = 1'b0;
        if (res_v && !res_m && m_q.size() > 0) void'(m_q.pop_front());
        if (m_run && !m_stall && ready) begin
          m_pc = (inst_v && take) ? m_tgt : m_seq;
          if (inst_v && spec) begin
            m_q.push_back(take ? m_seq : m_tgt);
            if (m_sb < 65535) m_sb++;
          end
        end
      end
      m_run = 1'b1;
    end
  end

  task automatic drive(input logic iv, input logic tk, input logic sp, input logic [15:0] o,
                       input logic rdy, input logic rv, input logic rm,
                       input logic dv, input logic [15:0] dpc);
    @(negedge clk);
    inst_v = iv; take = tk; spec = sp; off = o; ready = rdy;
    res_v = rv; res_m = rm; redir_v = dv; redir_pc = dpc;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
  endtask

  task automatic spec_nt();
    drive(1, 0, 1, 16'h0020, 1, 0, 0, 0, 16'h0000);
  endtask

  initial begin
    idle();
    chk("lit_rst_pc",   pc,   16'h0000);
    chk("lit_rst_pcv",  pc_v, 1'b0);
    chk("lit_rst_cnt",  cnt,  3'd0);
    idle();
    @(negedge clk); reset_i = 1'b0; #2;
    chk("lit_rel_pcv", pc_v, 1'b0);

    idle();   chk("lit_seq0", pc, 16'h0000); chk("lit_seq0_v", pc_v, 1'b1);
    idle();   chk("lit_seq1", pc, 16'h0002);
    drive(0, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0010);
    chk("lit_seq2", pc, 16'h0004);
    drive(1, 1, 1, 16'hFFF0, 1, 0, 0, 0, 16'h0000);
    chk("lit_redir_pc", pc, 16'h0010); chk("lit_redir_fl", flush, 1'b1);
    drive(1, 1, 1, 16'h0040, 1, 1, 1, 0, 16'h0000);
    chk("lit_tgt_pc", pc, 16'h0000); chk("lit_tgt_cnt", cnt, 3'd1); chk("lit_tgt_fl", flush, 1'b0);

    spec_nt();
    chk("lit_misp_pc", pc, 16'h0012); chk("lit_misp_fl", flush, 1'b1); chk("lit_misp_cnt", cnt, 3'd0);
    spec_nt();
    spec_nt();
    spec_nt();
    chk("lit_fill_pc", pc, 16'h0018); chk("lit_fill_cnt", cnt, 3'd3);
    spec_nt();
    chk("lit_full_cnt", cnt, 3'd4); chk("lit_stall", stall, 1'b1); chk("lit_stall_pcv", pc_v, 1'b0);
    drive(1, 0, 1, 16'h0020, 1, 1, 0, 0, 16'h0000);
    chk("lit_held_pc", pc, 16'h001A); chk("lit_nostall", stall, 1'b0);
    drive(1, 0, 1, 16'h0020, 1, 1, 1, 1, 16'h1234);
    chk("lit_pp_pc", pc, 16'h001C); chk("lit_pp_cnt", cnt, 3'd4);
    drive(1, 1, 0, 16'h0004, 0, 0, 0, 0, 16'h0000);
    chk("lit_r2_pc", pc, 16'h1234); chk("lit_r2_fl", flush, 1'b1); chk("lit_r2_cnt", cnt, 3'd0);
    drive(1, 1, 0, 16'h0004, 1, 0, 0, 0, 16'h0000);
    chk("lit_nrdy_pc", pc, 16'h1234); chk("lit_single_fl", flush, 1'b0);
    idle();
    chk("lit_b_pc", pc, 16'h1238); chk("lit_b_cnt", cnt, 3'd0);
    drive(0, 0, 0, 16'h0000, 1, 0, 0, 1, 16'hFFFE);
    chk("lit_b_seq", pc, 16'h123A);
    idle();
    chk("lit_ffe", pc, 16'hFFFE);
    drive(0, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0100);
    chk("lit_wrap", pc, 16'h0000);
    drive(0, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0200);
    chk("lit_bb1_pc", pc, 16'h0100); chk("lit_bb1_fl", flush, 1'b1);
    idle();
    chk("lit_bb2_pc", pc, 16'h0200); chk("lit_bb2_fl", flush, 1'b1);
    spec_nt();
    chk("lit_bb3_fl", flush, 1'b0);
    spec_nt();
    spec_nt();
    idle();
    chk("lit_pre_rst_cnt", cnt, 3'd3); chk("lit_pre_rst_pc", pc, 16'h0208);

    @(negedge clk); #1; reset_i = 1'b1; #1;
    chk("lit_arst_pc",  pc,    16'h0000);
    chk("lit_arst_cnt", cnt,   3'd0);
    chk("lit_arst_fl",  flush, 1'b0);
    chk("lit_arst_pcv", pc_v,  1'b0);
    @(negedge clk);
    @(negedge clk); reset_i = 1'b0; #2;

    spec_nt();
    chk("lit_s0_pc", pc, 16'h0000);
    spec_nt();
    spec_nt();
    drive(0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000);
    chk("lit_s3_cnt", cnt, 3'd3); chk("lit_s3_pc", pc, 16'h0006);
    idle();
    chk("lit_s_misp_pc", pc, 16'h0020); chk("lit_s_misp_fl", flush, 1'b1);
`ifdef FE_PC_GEN_STATS_EN
    chk("lit_stat_sb", sb, 16'd3);
    chk("lit_stat_mp", mp, 16'd1);
`endif
    idle();
    idle();
    @(negedge clk); #4;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
